// File: rtl/output_uart_pkg.sv
// output_uart_pkg: shared FSM encoding and UART framing constants for output_uart_tx.
// Exports the state enum, start/stop line levels, the data bit count and an even-parity helper.
// Optional macro OUTPUT_UART_PARITY_EN adds the PARITY state (8E1 instead of 8N1).
package output_uart_pkg;

  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;
  localparam int   UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef OUTPUT_UART_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_state_e;

  // Even parity bit: makes the total count of ones (data + parity) even.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period divider; emits a one-cycle Tick on the last cycle of every bit.
// Ports: Clk, Rst (async active-low), Restart (hold counter at 0), Tick (count == CLK_DIV-1).
// Latency: Tick is combinational from the count register; no backpressure, free-running when not restarted.
module uart_baud_tick #(
  parameter int unsigned CLK_DIV = 868
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Restart,
  output logic Tick
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  logic [15:0] div_cnt_q;
  logic [15:0] div_cnt_d;

  // Tick is suppressed while held in restart so the first bit of a frame
  // always gets its full CLK_DIV cycles.
  assign Tick = !Restart && (div_cnt_q == DIV_LAST);

  always_comb begin
    div_cnt_d = div_cnt_q + 16'd1;
    if (Restart || Tick) begin
      div_cnt_d = 16'd0;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      div_cnt_q <= 16'd0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/output_uart_tx.sv
// output_uart_tx: serialises every new CpuOutput value as two UART bytes (high byte first) on Tx.
// Ports: Clk, Rst (async active-low), CpuOutput[15:0], OverrunClr in; Tx, Busy, Overrun out.
// Latency: value change at edge N -> Tx start bit at edge N+2; a pair takes 20 (22 with parity) bit times.
// Optional macro OUTPUT_UART_PARITY_EN inserts an even parity bit after the data bits.
module output_uart_tx
  import output_uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = 868
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [15:0] CpuOutput,
  output logic        Tx,
  output logic        Busy,
  output logic        Overrun,
  input  logic        OverrunClr
);

  uart_state_e state_q, state_d;
  logic [15:0] last_sent_q, last_sent_d;
  logic [15:0] pending_q, pending_d;
  logic        pending_vld_q, pending_vld_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        byte_sel_q, byte_sel_d;
  logic        overrun_q, overrun_d;
  logic        tx_q, tx_d;
  logic        busy_q;
  logic        tick;
`ifdef OUTPUT_UART_PARITY_EN
  logic        parity_q, parity_d;
`endif

  uart_baud_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_baud (
    .Clk    (Clk),
    .Rst    (Rst),
    .Restart(state_q == ST_IDLE),
    .Tick   (tick)
  );

  // Next-state and datapath
  always_comb begin
    state_d       = state_q;
    last_sent_d   = last_sent_q;
    pending_d     = pending_q;
    pending_vld_d = pending_vld_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    byte_sel_d    = byte_sel_q;
    overrun_d     = overrun_q;
`ifdef OUTPUT_UART_PARITY_EN
    parity_d      = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (pending_vld_q) begin
          last_sent_d   = pending_q;
          pending_vld_d = 1'b0;
          shift_d       = pending_q[15:8];
          byte_sel_d    = 1'b0;
`ifdef OUTPUT_UART_PARITY_EN
          parity_d      = even_parity(pending_q[15:8]);
`endif
          state_d       = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          bit_cnt_d = 3'd0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef OUTPUT_UART_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef OUTPUT_UART_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (!byte_sel_q) begin
            // Second byte follows immediately, no idle gap.
            shift_d    = last_sent_q[7:0];
            byte_sel_d = 1'b1;
`ifdef OUTPUT_UART_PARITY_EN
            parity_d   = even_parity(last_sent_q[7:0]);
`endif
            state_d    = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Change detect compares against the post-copy LastSent/Pending so a
    // value arriving in the same cycle IDLE launches a frame lands in Pending
    // behind the value being sent, and a return to LastSent never cancels a
    // value still waiting.
    if (OverrunClr) begin
      overrun_d = 1'b0;
    end
    if ((CpuOutput != last_sent_d) && (!pending_vld_d || (CpuOutput != pending_d))) begin
      if (pending_vld_d) begin
        overrun_d = 1'b1;  // set wins over a simultaneous clear
      end
      pending_d     = CpuOutput;
      pending_vld_d = 1'b1;
    end
  end

  // Line level is registered from the next state so Tx and Busy move together.
  always_comb begin
    tx_d = UART_STOP_BIT;
    case (state_d)
      ST_START:  tx_d = UART_START_BIT;
      ST_DATA:   tx_d = shift_d[0];
`ifdef OUTPUT_UART_PARITY_EN
      ST_PARITY: tx_d = parity_d;
`endif
      default:   tx_d = UART_STOP_BIT;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q       <= ST_IDLE;
      last_sent_q   <= 16'h0000;
      pending_q     <= 16'h0000;
      pending_vld_q <= 1'b0;
      shift_q       <= 8'h00;
      bit_cnt_q     <= 3'd0;
      byte_sel_q    <= 1'b0;
      overrun_q     <= 1'b0;
      tx_q          <= UART_STOP_BIT;
      busy_q        <= 1'b0;
`ifdef OUTPUT_UART_PARITY_EN
      parity_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      last_sent_q   <= last_sent_d;
      pending_q     <= pending_d;
      pending_vld_q <= pending_vld_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_sel_q    <= byte_sel_d;
      overrun_q     <= overrun_d;
      tx_q          <= tx_d;
      busy_q        <= (state_d != ST_IDLE);
`ifdef OUTPUT_UART_PARITY_EN
      parity_q      <= parity_d;
`endif
    end
  end

  assign Tx      = tx_q;
  assign Busy    = busy_q;
  assign Overrun = overrun_q;

endmodule

// File: tb/tb_output_uart_tx.sv
// tb_output_uart_tx: directed bench for output_uart_tx with CLK_DIV = 4.
// A line monitor decodes UART frames and checks them against a byte scoreboard.
// Honours OUTPUT_UART_PARITY_EN for frame shape and frame-pair length.
module tb_output_uart_tx;

  localparam int DIV = 4;
`ifdef OUTPUT_UART_PARITY_EN
  localparam int FB       = 11;
  localparam int BUSY_CYC = 88;
`else
  localparam int FB       = 10;
  localparam int BUSY_CYC = 80;
`endif

  logic        Clk;
  logic        Rst;
  logic [15:0] CpuOutput;
  logic        Tx;
  logic        Busy;
  logic        Overrun;
  logic        OverrunClr;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  output_uart_tx #(.CLK_DIV(DIV)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .CpuOutput (CpuOutput),
    .Tx        (Tx),
    .Busy      (Busy),
    .Overrun   (Overrun),
    .OverrunClr(OverrunClr)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // UART line monitor: samples each bit in its middle, drops frames cut by reset.
  initial begin : monitor
    logic        prev;
    logic [10:0] frm;
    logic [10:0] efrm;
    logic [7:0]  eb;
    bit          aborted;
    prev = 1'b1;
    forever begin
      @(negedge Clk);
      if (Rst && prev && !Tx) begin
        frm     = '0;
        aborted = 1'b0;
        for (int j = 1; j <= (FB - 1) * DIV + 2; j++) begin
          @(negedge Clk);
          if (!Rst) aborted = 1'b1;
          if (j % DIV == 2) frm[j / DIV] = Tx;
        end
        if (!aborted) begin
          check("rx_frame_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            eb = exp_q.pop_front();
`ifdef OUTPUT_UART_PARITY_EN
            efrm = {1'b1, ^eb, eb, 1'b0};
`else
            efrm = {1'b0, 1'b1, eb, 1'b0};
`endif
            check("rx_frame", 32'(frm), 32'(efrm));
          end
        end
      end
      prev = Tx;
    end
  end

  task automatic drive(input logic [15:0] v);
    @(posedge Clk);
    #1 CpuOutput = v;
  endtask

  task automatic send(input logic [15:0] v);
    exp_q.push_back(v[15:8]);
    exp_q.push_back(v[7:0]);
    drive(v);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic idle_check(input string tag, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      if (Tx !== 1'b1 || Busy !== 1'b0) bad++;
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  task automatic wait_drain(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(posedge Clk);
      #1;
      if (exp_q.size() == 0 && !Busy) done = 1'b1;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  // Called right after drive(): checks the 2-cycle launch and Busy width.
  task automatic measure_busy(input string tag);
    int  cnt;
    bit  low;
    step(1);
    check({tag, "_busy_n1"}, 32'(Busy), 32'd0);
    step(1);
    check({tag, "_busy_n2"}, 32'(Busy), 32'd1);
    check({tag, "_tx_n2"}, 32'(Tx), 32'd0);
    cnt = 1;
    low = 1'b0;
    for (int i = 0; i < 300 && !low; i++) begin
      step(1);
      if (Busy) cnt++;
      else low = 1'b1;
    end
    check({tag, "_busy_len"}, 32'(cnt), 32'(BUSY_CYC));
  endtask

  initial begin
    Rst        = 1'b0;
    CpuOutput  = 16'h0000;
    OverrunClr = 1'b0;

    // Reset state
    step(3);
    check("rst_tx", 32'(Tx), 32'd1);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_overrun", 32'(Overrun), 32'd0);
    @(negedge Clk);
    Rst = 1'b1;
    idle_check("idle_after_reset", 200);

    // Single value, launch latency and pair length
    send(16'hA55A);
    measure_busy("a55a");
    wait_drain("a55a_drain");
    check("a55a_no_overrun", 32'(Overrun), 32'd0);

    // Overwritten pending value and overrun flag
    send(16'h1234);
    step(10);
    drive(16'h5678);
    step(40);
    send(16'h9ABC);
    step(2);
    check("overrun_set", 32'(Overrun), 32'd1);
    wait_drain("overrun_drain");
    check("overrun_sticky", 32'(Overrun), 32'd1);
    @(posedge Clk);
    #1 OverrunClr = 1'b1;
    @(posedge Clk);
    #1 OverrunClr = 1'b0;
    check("overrun_clr", 32'(Overrun), 32'd0);

    // Return to zero while a frame is in flight
    send(16'h00FF);
    step(20);
    send(16'h0000);
    wait_drain("zero_drain");
    check("last_sent_zero", 32'(dut.last_sent_q), 32'h0000);
    check("zero_no_overrun", 32'(Overrun), 32'd0);

    // Reset in the third data bit of the high byte
    drive(16'h3C3C);
    step(14);
    check("pre_reset_busy", 32'(Busy), 32'd1);
    check("pre_reset_bit2", 32'(Tx), 32'd1);
    #1;
    Rst       = 1'b0;
    CpuOutput = 16'h0000;
    #1;
    check("mid_reset_tx", 32'(Tx), 32'd1);
    check("mid_reset_busy", 32'(Busy), 32'd0);
    repeat (3) @(negedge Clk);
    Rst = 1'b1;
    idle_check("idle_after_midreset", 100);
    send(16'h0001);
    wait_drain("post_reset_drain");

`ifdef OUTPUT_UART_PARITY_EN
    // Parity frames
    send(16'h0701);
    measure_busy("par0701");
    wait_drain("par_drain");
`endif

    step(5);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
